// File: rtl/mult_booth_if.sv
// mult_booth_if -- handshake and operand/result bundle for mult_booth.
//
// Signals:
//   start      request, accepted on a rising edge while busy is low
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   x, y       multiplicand / multiplier (sampled with start)
//   busy       high from accept until the result edge
//   fim        one-cycle pulse; hi/lo valid from this cycle
//   hi, lo     upper / lower halves of the 2*WIDTH-bit product
//
// Modports: master (control unit side), slave (multiplier side).
interface mult_booth_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             fim;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, x, y,
        input  busy, fim, hi, lo
    );

    modport slave (
        input  start, is_signed, x, y,
        output busy, fim, hi, lo
    );
endinterface

// File: rtl/mult_booth.sv
// mult_booth -- multicycle radix-2 Booth multiplier, signed or unsigned.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    mult_booth_if.slave: start/is_signed/x/y in, busy/fim/hi/lo out
//
// Parameters:
//   WIDTH  operand width (>= 4); product is 2*WIDTH bits
//
// Optional build macro:
//   MULT_ZERO_BYPASS_EN  when defined, a zero operand skips the Booth steps
//                        and the (zero) result is produced one cycle after
//                        accept.
//
// Timing: accept edge E0, Booth steps on E1..E(WIDTH+1), hi/lo/fim updated
// on E(WIDTH+2). hi/lo hold until the next completion or reset.
module mult_booth #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    mult_booth_if.slave bus
);
    // Operands are extended by one bit so unsigned values and the negation
    // of the most negative signed value both fit; P carries an extra LSB
    // for the Booth pair.
    localparam int PW = 2 * (WIDTH + 1) + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    a;
    logic [PW-1:0]    s;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_sum;
    logic [PW-1:0]    p_next;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             fim_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH:0]   x_ext;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   x_neg;

    assign bus.busy = busy_q;
    assign bus.fim  = fim_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_comb begin
        x_ext = bus.is_signed ? {bus.x[WIDTH-1], bus.x} : {1'b0, bus.x};
        y_ext = bus.is_signed ? {bus.y[WIDTH-1], bus.y} : {1'b0, bus.y};
        x_neg = -x_ext;
    end

    // One Booth step: add/subtract multiplicand by the low pair, then
    // arithmetic shift right.
    always_comb begin
        p_sum = p;
        case (p[1:0])
            2'b01:   p_sum = p + a;
            2'b10:   p_sum = p + s;
            default: p_sum = p;
        endcase
        p_next = {p_sum[PW-1], p_sum[PW-1:1]};
    end

`ifdef MULT_ZERO_BYPASS_EN
    logic zero_op;
    always_comb begin
        zero_op = (bus.x == '0) || (bus.y == '0);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            a      <= '0;
            s      <= '0;
            p      <= '0;
            busy_q <= 1'b0;
            fim_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            fim_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a      <= {x_ext, {(WIDTH + 2){1'b0}}};
                        s      <= {x_neg, {(WIDTH + 2){1'b0}}};
                        p      <= {{(WIDTH + 1){1'b0}}, y_ext, 1'b0};
                        count  <= '0;
                        busy_q <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                        // P must read as zero in DONE, so it is cleared
                        // rather than loaded with y.
                        if (zero_op) begin
                            p     <= '0;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state  <= RUN;
`endif
                    end
                end
                RUN: begin
                    p     <= p_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi_q   <= p[2*WIDTH:WIDTH+1];
                    lo_q   <= p[WIDTH:1];
                    fim_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth -- self-checking bench for mult_booth at WIDTH=32 and WIDTH=8.
// Expected products are queued when an operation is launched and popped
// when fim is observed.
module tb_mult_booth;
    logic clk;
    logic reset;

    int check_count;
    int pass_count;

    logic [63:0] q32[$];
    logic [15:0] q8[$];

    mult_booth_if #(.WIDTH(32)) bus32 ();
    mult_booth_if #(.WIDTH(8))  bus8 ();

    mult_booth #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    mult_booth #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 34;
    localparam int ZERO_BUSY = 33;
`endif

    function automatic logic [63:0] model32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Drives a request from a negedge; returns at the negedge after the accept edge.
    task automatic launch32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bus32.is_signed = sgn;
        bus32.x         = a;
        bus32.y         = b;
        bus32.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.start     = 1'b0;
        bus32.x         = $urandom;
        bus32.y         = $urandom;
        bus32.is_signed = ~sgn;
    endtask

    task automatic launch8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        bus8.is_signed = sgn;
        bus8.x         = a;
        bus8.y         = b;
        bus8.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start     = 1'b0;
        bus8.x         = 8'($urandom);
        bus8.y         = 8'($urandom);
    endtask

    // Counts negedges until fim (cycles == limit means it never came).
    task automatic wait_fim(input bit narrow, input int limit, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (narrow ? bus8.fim : bus32.fim) break;
            if (narrow ? bus8.busy : bus32.busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.x = '0; bus32.y = '0;
        bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.x  = '0; bus8.y  = '0;
        repeat (3) @(negedge clk);
        check_count++;
        if ({bus32.busy, bus32.fim, bus32.hi, bus32.lo} !== 66'b0)
            $display("FAIL reset32: busy=%b fim=%b hi=%h lo=%h, required all 0", bus32.busy, bus32.fim, bus32.hi, bus32.lo);
        else pass_count++;
        check_count++;
        if ({bus8.busy, bus8.fim, bus8.hi, bus8.lo} !== 18'b0)
            $display("FAIL reset8: busy=%b fim=%b hi=%h lo=%h, required all 0", bus8.busy, bus8.fim, bus8.hi, bus8.lo);
        else pass_count++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_basic();
        int c, b;
        logic [63:0] want;
        launch32(1'b1, 32'hFFFF_FFFD, 32'd7);
        q32.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        check_count++;
        if (bus32.busy !== 1'b1) $display("FAIL busy_after_accept: got %b, required 1", bus32.busy);
        else pass_count++;
        wait_fim(1'b0, 60, c, b);
        check_count++;
        if (c !== 34) $display("FAIL latency_signed: got %0d, required 34", c);
        else pass_count++;
        check_count++;
        if (b !== 33) $display("FAIL busy_len: got %0d more cycles, required 33", b);
        else pass_count++;
        check_count++;
        if (bus32.busy !== 1'b0) $display("FAIL busy_at_fim: got %b, required 0", bus32.busy);
        else pass_count++;
        want = q32.pop_front();
        check_count++;
        if ({bus32.hi, bus32.lo} !== want) $display("FAIL prod_m3x7: got %h, required %h", {bus32.hi, bus32.lo}, want);
        else pass_count++;
        repeat (3) @(negedge clk);
        check_count++;
        if ({bus32.fim, bus32.hi, bus32.lo} !== {1'b0, want}) $display("FAIL hold_after_fim: got fim=%b %h, required 0 %h", bus32.fim, {bus32.hi, bus32.lo}, want);
        else pass_count++;
    endtask

    task automatic test_extremes();
        int c, b;
        logic [63:0] want;
        logic [31:0] ops[3][2] = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{32'h8000_0000, 32'h8000_0000}};
        bit          sgns[3]   = '{1'b0, 1'b1, 1'b1};
        logic [63:0] wants[3]  = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000};
        for (int i = 0; i < 3; i++) begin
            launch32(sgns[i], ops[i][0], ops[i][1]);
            q32.push_back(wants[i]);
            wait_fim(1'b0, 60, c, b);
            want = q32.pop_front();
            check_count++;
            if ({bus32.hi, bus32.lo} !== want || c !== 34)
                $display("FAIL extreme_%0d: got %h after %0d cycles, required %h after 34", i, {bus32.hi, bus32.lo}, c, want);
            else pass_count++;
        end
    endtask

    task automatic test_back_to_back();
        int c, b;
        logic [63:0] want;
        launch32(1'b1, 32'd6, 32'd7);
        q32.push_back(64'd42);
        repeat (5) @(negedge clk);
        bus32.start = 1'b1; bus32.is_signed = 1'b1; bus32.x = 32'd100; bus32.y = 32'd100;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_fim(1'b0, 60, c, b);
        check_count++;
        if (c + 6 !== 34) $display("FAIL ignore_latency: got %0d, required 34", c + 6);
        else pass_count++;
        want = q32.pop_front();
        check_count++;
        if ({bus32.hi, bus32.lo} !== want) $display("FAIL ignore_start: got %h, required %h", {bus32.hi, bus32.lo}, want);
        else pass_count++;
        // start raised during the fim cycle
        launch32(1'b1, 32'hFFFF_FFFF, 32'd1);
        q32.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        check_count++;
        if (bus32.busy !== 1'b1) $display("FAIL start_in_fim_accept: busy got %b, required 1", bus32.busy);
        else pass_count++;
        wait_fim(1'b0, 60, c, b);
        want = q32.pop_front();
        check_count++;
        if ({bus32.hi, bus32.lo} !== want || c !== 34)
            $display("FAIL back_to_back: got %h after %0d, required %h after 34", {bus32.hi, bus32.lo}, c, want);
        else pass_count++;
    endtask

    task automatic test_reset_midrun();
        int c, b;
        logic [63:0] want;
        launch32(1'b0, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check_count++;
        if ({bus32.busy, bus32.fim, bus32.hi, bus32.lo} !== 66'b0)
            $display("FAIL async_reset: busy=%b fim=%b hi=%h lo=%h, required all 0", bus32.busy, bus32.fim, bus32.hi, bus32.lo);
        else pass_count++;
        @(negedge clk);
        reset = 1'b1;
        wait_fim(1'b0, 40, c, b);
        check_count++;
        if (c !== 40) $display("FAIL no_fim_after_reset: fim at %0d, required none in 40", c);
        else pass_count++;
        launch32(1'b1, 32'd2, 32'd3);
        q32.push_back(64'd6);
        wait_fim(1'b0, 60, c, b);
        want = q32.pop_front();
        check_count++;
        if ({bus32.hi, bus32.lo} !== want) $display("FAIL after_reset_2x3: got %h, required %h", {bus32.hi, bus32.lo}, want);
        else pass_count++;
    endtask

    task automatic test_zero();
        int c, b;
        logic [63:0] want;
        launch32(1'b1, 32'd0, 32'h1234);
        q32.push_back(64'd0);
        wait_fim(1'b0, 60, c, b);
        want = q32.pop_front();
        check_count++;
        if ({bus32.hi, bus32.lo} !== want) $display("FAIL zero_prod: got %h, required %h", {bus32.hi, bus32.lo}, want);
        else pass_count++;
        check_count++;
        if (c !== ZERO_LAT || b !== ZERO_BUSY)
            $display("FAIL zero_latency: got %0d/%0d, required %0d/%0d", c, b, ZERO_LAT, ZERO_BUSY);
        else pass_count++;
    endtask

    task automatic test_random();
        int c, b;
        bit sgn;
        logic [31:0] a, bb;
        logic [63:0] want;
        for (int i = 0; i < 6; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            bb  = $urandom;
            launch32(sgn, a, bb);
            q32.push_back(model32(sgn, a, bb));
            wait_fim(1'b0, 60, c, b);
            want = q32.pop_front();
            check_count++;
            if ({bus32.hi, bus32.lo} !== want)
                $display("FAIL random_%0d: s=%b %h*%h got %h, required %h", i, sgn, a, bb, {bus32.hi, bus32.lo}, want);
            else pass_count++;
        end
    endtask

    task automatic test_width8();
        int c, b;
        logic [15:0] want;
        launch8(1'b1, 8'h80, 8'h7F);
        q8.push_back(16'hC080);
        wait_fim(1'b1, 30, c, b);
        want = q8.pop_front();
        check_count++;
        if ({bus8.hi, bus8.lo} !== want || c !== 10)
            $display("FAIL w8_signed: got %h after %0d, required %h after 10", {bus8.hi, bus8.lo}, c, want);
        else pass_count++;
        launch8(1'b0, 8'hFF, 8'hFF);
        q8.push_back(16'hFE01);
        wait_fim(1'b1, 30, c, b);
        want = q8.pop_front();
        check_count++;
        if ({bus8.hi, bus8.lo} !== want || c !== 10)
            $display("FAIL w8_unsigned: got %h after %0d, required %h after 10", {bus8.hi, bus8.lo}, c, want);
        else pass_count++;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        test_reset();
        test_signed_basic();
        test_extremes();
        test_back_to_back();
        test_reset_midrun();
        test_zero();
        test_random();
        test_width8();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
